// File: rtl/ysyx22041405_lsu.sv
// Load/store stage between execute and write-back: captures one instruction, runs a
// request/acknowledge access for aligned loads/stores and holds the result for write-back.
module ysyx22041405_lsu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [WIDTH-1:0] ex_alu_result,
    input  logic [WIDTH-1:0] ex_store_data,
    input  logic [WIDTH-1:0] ex_pc,
    input  logic [WIDTH-1:0] ex_inst,
    input  logic             ex_mem_re,
    input  logic             ex_mem_we,
    input  logic [1:0]       ex_mem_size,
    input  logic             ex_mem_unsigned,
    input  logic             ex_rf_we,
    input  logic [4:0]       ex_rf_waddr,
    output logic             mem_req,
    output logic             mem_wr,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic             wb_rf_we,
    output logic [4:0]       wb_rf_waddr,
    output logic [WIDTH-1:0] wb_rf_wdata,
    output logic [WIDTH-1:0] wb_pc,
    output logic [WIDTH-1:0] wb_inst,
    output logic             wb_misalign
);

    localparam int unsigned STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              accept;
    logic              ex_is_mem;
    logic              ex_mis;
    logic              ex_to_mem;
    logic [WIDTH-1:0]  st_wdata;
    logic [STRB_W-1:0] st_strb;

    logic [1:0]        ld_off;
    logic [1:0]        ld_size;
    logic              ld_unsigned;
    logic              ld_load;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [WIDTH-1:0]  ld_data;

    assign accept    = ex_valid & ex_ready;
    assign ex_is_mem = ex_mem_re | ex_mem_we;
    assign ex_to_mem = ex_is_mem & ~ex_mis;

    // Misalignment check and store lane formatting for the incoming instruction
    always_comb begin
        ex_mis   = 1'b0;
        st_wdata = ex_store_data;
        st_strb  = 4'b1111;
        case (ex_mem_size)
            2'b00: begin
                st_wdata = {4{ex_store_data[7:0]}};
                st_strb  = 4'b0001 << ex_alu_result[1:0];
            end
            2'b01: begin
                ex_mis   = ex_is_mem & ex_alu_result[0];
                st_wdata = {2{ex_store_data[15:0]}};
                st_strb  = 4'b0011 << ex_alu_result[1:0];
            end
            default: begin
                ex_mis = ex_is_mem & (|ex_alu_result[1:0]);
            end
        endcase
    end

    // Load lane extraction from the returned word
    always_comb begin
        ld_byte = mem_rdata[{ld_off, 3'b000} +: 8];
        ld_half = mem_rdata[{ld_off[1], 4'b0000} +: 16];
        case (ld_size)
            2'b00:   ld_data = {{(WIDTH-8){ld_byte[7] & ~ld_unsigned}}, ld_byte};
            2'b01:   ld_data = {{(WIDTH-16){ld_half[15] & ~ld_unsigned}}, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = ex_to_mem ? MEM : RESP;
            end
            MEM: begin
                if (mem_ack) state_nxt = RESP;
            end
            RESP: begin
                if (wb_ready) begin
                    if (accept) state_nxt = ex_to_mem ? MEM : RESP;
                    else        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ex_ready = 1'b0;
        mem_req  = 1'b0;
        wb_valid = 1'b0;
        case (state)
            IDLE: ex_ready = 1'b1;
            MEM:  mem_req  = 1'b1;
            RESP: begin
                wb_valid = 1'b1;
                ex_ready = wb_ready;
            end
            default: ex_ready = 1'b0;
        endcase
    end

    // Capture on acceptance; a load overwrites the write-back data when memory acknowledges
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wstrb   <= '0;
            wb_rf_we    <= 1'b0;
            wb_rf_waddr <= '0;
            wb_rf_wdata <= '0;
            wb_pc       <= '0;
            wb_inst     <= '0;
            wb_misalign <= 1'b0;
            ld_off      <= '0;
            ld_size     <= '0;
            ld_unsigned <= 1'b0;
            ld_load     <= 1'b0;
        end else begin
            if (accept) begin
                mem_wr      <= ex_mem_we;
                mem_addr    <= {ex_alu_result[WIDTH-1:2], 2'b00};
                mem_wdata   <= st_wdata;
                mem_wstrb   <= ex_mem_we ? st_strb : 4'b0000;
                wb_rf_we    <= ex_rf_we & ~ex_mis;
                wb_rf_waddr <= ex_rf_waddr;
                wb_rf_wdata <= ex_alu_result;
                wb_pc       <= ex_pc;
                wb_inst     <= ex_inst;
                wb_misalign <= ex_mis;
                ld_off      <= ex_alu_result[1:0];
                ld_size     <= ex_mem_size;
                ld_unsigned <= ex_mem_unsigned;
                ld_load     <= ex_mem_re & ~ex_mem_we;
            end
            if ((state == MEM) && mem_ack && ld_load) begin
                wb_rf_wdata <= ld_data;
            end
        end
    end

endmodule

// File: tb/tb_ysyx22041405_lsu.sv
// Scoreboard bench for the LSU: directed scenarios plus randomized instructions checked
// against a reference model of the write-back and memory-request behaviour.
module tb_ysyx22041405_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [31:0] ex_alu_result = '0;
    logic [31:0] ex_store_data = '0;
    logic [31:0] ex_pc = '0;
    logic [31:0] ex_inst = '0;
    logic        ex_mem_re = 1'b0;
    logic        ex_mem_we = 1'b0;
    logic [1:0]  ex_mem_size = '0;
    logic        ex_mem_unsigned = 1'b0;
    logic        ex_rf_we = 1'b0;
    logic [4:0]  ex_rf_waddr = '0;
    logic        mem_req;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        wb_valid;
    logic        wb_ready = 1'b1;
    logic        wb_rf_we;
    logic [4:0]  wb_rf_waddr;
    logic [31:0] wb_rf_wdata;
    logic [31:0] wb_pc;
    logic [31:0] wb_inst;
    logic        wb_misalign;

    ysyx22041405_lsu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_pc(ex_pc), .ex_inst(ex_inst),
        .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we),
        .ex_mem_size(ex_mem_size), .ex_mem_unsigned(ex_mem_unsigned),
        .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_rf_we(wb_rf_we), .wb_rf_waddr(wb_rf_waddr), .wb_rf_wdata(wb_rf_wdata),
        .wb_pc(wb_pc), .wb_inst(wb_inst), .wb_misalign(wb_misalign)
    );

    typedef struct {
        logic [31:0] pc, inst, alu, sd;
        logic        re, we, uns, rf_we;
        logic [1:0]  sz;
        logic [4:0]  waddr;
    } ins_t;

    typedef struct {
        logic [31:0] pc, inst, wdata;
        logic [4:0]  waddr;
        logic        rf_we, mis, via_mem;
        int          acc;
    } wb_exp_t;

    typedef struct {
        logic [31:0] addr, wdata;
        logic [3:0]  wstrb;
        logic        wr;
        int          acc;
    } mem_exp_t;

    wb_exp_t  wb_q[$];
    mem_exp_t mem_q[$];
    logic [31:0] mem_img [logic [31:0]];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_ack_cyc = 0;
    int forced_wait = -1;
    bit mem_auto = 1'b1;
    bit rdy_force = 1'b1;
    bit rdy_val = 1'b1;
    bit fresh = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Reference model: result seen by write-back for one instruction
    function automatic wb_exp_t ref_wb(input ins_t i, input int acc);
        wb_exp_t     e;
        logic [31:0] rd, v;
        int unsigned off;
        bit          ismem, mis;
        ismem = i.re || i.we;
        off   = i.alu % 4;
        mis   = ismem && ((i.sz == 2'd1 && off % 2 == 1) || (i.sz >= 2'd2 && off != 0));
        e.pc = i.pc; e.inst = i.inst; e.waddr = i.waddr; e.acc = acc;
        e.mis = mis; e.rf_we = i.rf_we && !mis; e.wdata = i.alu; e.via_mem = ismem && !mis;
        if (ismem && !mis && !i.we) begin
            rd = mem_word(i.alu & 32'hFFFF_FFFC);
            if (i.sz == 2'd0) begin
                v = (rd >> (8 * off)) & 32'hFF;
                if (!i.uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end else if (i.sz == 2'd1) begin
                v = (rd >> (16 * (off / 2))) & 32'hFFFF;
                if (!i.uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end else begin
                v = rd;
            end
            e.wdata = v;
        end
        return e;
    endfunction

    function automatic mem_exp_t ref_mem(input ins_t i, input int acc);
        mem_exp_t    m;
        int unsigned off;
        off = i.alu % 4;
        m.addr = i.alu & 32'hFFFF_FFFC; m.wr = i.we; m.acc = acc;
        case (i.sz)
            2'd0: begin m.wdata = (i.sd & 32'hFF) * 32'h0101_0101; m.wstrb = 4'(1 << off); end
            2'd1: begin m.wdata = (i.sd & 32'hFFFF) * 32'h0001_0001; m.wstrb = 4'(3 << off); end
            default: begin m.wdata = i.sd; m.wstrb = 4'hF; end
        endcase
        return m;
    endfunction

    function automatic ins_t mk(input logic [31:0] alu, input logic [31:0] sd, input logic re,
                                input logic we, input logic [1:0] sz, input logic uns,
                                input logic rf_we, input logic [4:0] waddr);
        ins_t i;
        i.pc = $urandom(); i.inst = $urandom(); i.alu = alu; i.sd = sd; i.re = re; i.we = we;
        i.sz = sz; i.uns = uns; i.rf_we = rf_we; i.waddr = waddr;
        return i;
    endfunction

    task automatic drive(input ins_t i);
        @(posedge clk); #1;
        ex_pc = i.pc; ex_inst = i.inst; ex_alu_result = i.alu; ex_store_data = i.sd;
        ex_mem_re = i.re; ex_mem_we = i.we; ex_mem_size = i.sz; ex_mem_unsigned = i.uns;
        ex_rf_we = i.rf_we; ex_rf_waddr = i.waddr; ex_valid = 1'b1;
    endtask

    task automatic wait_accept(input ins_t i);
        wb_exp_t e;
        int n = 0;
        while (n < 300) begin
            @(negedge clk);
            if (ex_ready === 1'b1) break;
            n++;
        end
        if (n >= 300) begin
            check("accept_timeout", 32'(n), 32'd0);
        end else begin
            e = ref_wb(i, cyc);
            wb_q.push_back(e);
            if (e.via_mem) mem_q.push_back(ref_mem(i, cyc));
        end
    endtask

    task automatic issue(input ins_t i);
        drive(i);
        wait_accept(i);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        ex_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (wb_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 32'(wb_q.size()), 32'd0);
    endtask

    // Write-back ready driver
    initial begin
        forever begin
            @(posedge clk); #2;
            wb_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
        end
    end

    // Memory responder: checks each request against the expected queue, acks after a wait
    initial begin
        mem_exp_t m;
        bit busy = 1'b0;
        int cnt = 0;
        forever begin
            @(posedge clk); #2;
            if (!mem_auto) begin
                busy = 1'b0;
                continue;
            end
            mem_ack = 1'b0;
            mem_rdata = $urandom();
            if (!rst) begin
                busy = 1'b0;
                continue;
            end
            if (mem_req === 1'b1 && !busy) begin
                busy = 1'b1;
                if (mem_q.size() == 0) begin
                    check("mem_req_unexpected", 32'(mem_req), 32'd0);
                    m.addr = mem_addr; m.wr = mem_wr; m.wdata = mem_wdata; m.wstrb = mem_wstrb;
                end else begin
                    m = mem_q.pop_front();
                    check("mem_req_latency", 32'(cyc), 32'(m.acc + 1));
                    check("mem_addr", mem_addr, m.addr);
                    check("mem_wr", 32'(mem_wr), 32'(m.wr));
                    if (m.wr) begin
                        check("mem_wdata", mem_wdata, m.wdata);
                        check("mem_wstrb", 32'(mem_wstrb), 32'(m.wstrb));
                    end
                end
                cnt = (forced_wait >= 0) ? forced_wait : $urandom_range(0, 3);
            end
            if (busy) begin
                check("mem_req_held", 32'(mem_req), 32'd1);
                check("mem_addr_held", mem_addr, m.addr);
                if (cnt == 0) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem_word(m.addr);
                    last_ack_cyc = cyc;
                    busy = 1'b0;
                end else begin
                    cnt--;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                mem_ack = 1'b1;
            end
        end
    end

    // Monitor: compares every presented write-back result with the queue head
    initial begin
        wb_exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && wb_valid === 1'b1) begin
                if (wb_q.size() == 0) begin
                    check("wb_unexpected", 32'(wb_valid), 32'd0);
                end else begin
                    e = wb_q[0];
                    if (fresh) begin
                        fresh = 1'b0;
                        check("wb_latency", 32'(cyc), 32'(e.via_mem ? last_ack_cyc + 1 : e.acc + 1));
                    end
                    check("wb_rf_wdata", wb_rf_wdata, e.wdata);
                    check("wb_rf_we", 32'(wb_rf_we), 32'(e.rf_we));
                    check("wb_rf_waddr", 32'(wb_rf_waddr), 32'(e.waddr));
                    check("wb_pc", wb_pc, e.pc);
                    check("wb_inst", wb_inst, e.inst);
                    check("wb_misalign", 32'(wb_misalign), 32'(e.mis));
                    if (wb_ready === 1'b1) begin
                        void'(wb_q.pop_front());
                        fresh = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        ins_t a, b;
        mem_img[32'h1000] = 32'h80FF_FFFF;

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("reset_ex_ready", 32'(ex_ready), 32'd1);
        check("reset_wb_valid", 32'(wb_valid), 32'd0);
        check("reset_mem_req", 32'(mem_req), 32'd0);

        // ALU pass-through
        issue(mk(32'h1234, 32'h0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 5'd5));
        idle();
        drain();

        // LB signed and unsigned with two wait cycles
        forced_wait = 2;
        issue(mk(32'h1003, $urandom(), 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 5'd7));
        issue(mk(32'h1003, $urandom(), 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 5'd8));
        idle();
        drain();

        // SH, then misaligned LW
        forced_wait = 1;
        issue(mk(32'h2002, 32'hAABB_CCDD, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 5'd0));
        issue(mk(32'h3001, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd9));
        idle();
        drain();
        forced_wait = -1;

        // Write-back stall with a waiting instruction
        rdy_val = 1'b0;
        a = mk(32'h55AA, 32'h0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 5'd10);
        b = mk(32'h66BB, 32'h0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 5'd11);
        issue(a);
        drive(b);
        repeat (3) begin
            @(negedge clk);
            check("stall_ex_ready", 32'(ex_ready), 32'd0);
        end
        @(posedge clk); #1 rdy_val = 1'b1;
        wait_accept(b);
        check("release_wb_valid", 32'(wb_valid), 32'd1);
        check("release_wb_inst", wb_inst, a.inst);
        idle();
        drain();

        // Reset during MEM followed by a late ack
        mem_auto = 1'b0;
        #3 mem_ack = 1'b0;
        issue(mk(32'h4000, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd12));
        idle();
        @(negedge clk);
        check("pre_reset_mem_req", 32'(mem_req), 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1; mem_ack = 1'b1;
        wb_q.delete();
        mem_q.delete();
        fresh = 1'b1;
        @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_ex_ready", 32'(ex_ready), 32'd1);
        check("rst_wb_pc", wb_pc, 32'd0);
        check("rst_wb_rf_wdata", wb_rf_wdata, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        @(posedge clk); #1 mem_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("late_ack_wb_valid", 32'(wb_valid), 32'd0);
            check("late_ack_mem_req", 32'(mem_req), 32'd0);
        end
        mem_auto = 1'b1;

        // Randomized traffic with random back-pressure and memory latency
        rdy_force = 1'b0;
        for (int n = 0; n < 300; n++) begin
            int          kind;
            logic [31:0] addr;
            kind = $urandom_range(0, 2);
            addr = $urandom();
            if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
            a = mk(addr, $urandom(), kind == 1 || (kind == 2 && $urandom_range(0, 1) == 1),
                   kind == 2, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
            issue(a);
            if ($urandom_range(0, 2) == 0) begin
                idle();
                repeat ($urandom_range(0, 2)) @(posedge clk);
            end
        end
        idle();
        rdy_force = 1'b1;
        rdy_val = 1'b1;
        drain();
        repeat (4) @(negedge clk);
        check("mem_queue_empty", 32'(mem_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx22041405_lsu.md
# ysyx22041405_lsu

Load/store stage that sits directly downstream of the execute stage and upstream of write-back. It latches one instruction's ALU result and control fields through a valid/ready handshake, runs a request/acknowledge memory transaction for loads and stores, and aligns, extends and strobes the data. It then holds the result for write-back until it is consumed. Non-memory instructions pass through with one cycle of latency.

## Interface
Parameters:
- WIDTH, 32, datapath and address width; only 32 is supported.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-low; sampled on the rising edge of clk.
- ex_valid  in  1  execute stage presents an instruction.
- ex_ready  out  1  LSU accepts the instruction this cycle.
- ex_alu_result  in  WIDTH  ALU result; effective address for memory operations.
- ex_store_data  in  WIDTH  rs2 value for stores.
- ex_pc, ex_inst  in  WIDTH each  passed through to write-back.
- ex_mem_re, ex_mem_we  in  1 each  load or store. Both set means store.
- ex_mem_size  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
- ex_mem_unsigned  in  1  zero-extend loads (LBU/LHU).
- ex_rf_we  in  1  register-file write enable.
- ex_rf_waddr  in  5  destination register.
- mem_req  out  1  memory request; held until acknowledged.
- mem_wr  out  1  1 = store, 0 = load.
- mem_addr  out  WIDTH  word-aligned address ({addr[31:2],2'b00}).
- mem_wdata  out  WIDTH  store data replicated per lane.
- mem_wstrb  out  4  byte strobes.
- mem_ack  in  1  transaction complete; mem_rdata is valid in the same cycle for loads.
- mem_rdata  in  WIDTH  read word.
- wb_valid  out  1  result held for write-back.
- wb_ready  in  1  write-back consumes the result.
- wb_rf_we  out  1  write-back register-file write enable.
- wb_rf_waddr  out  5  write-back destination register.
- wb_rf_wdata  out  WIDTH  write-back data.
- wb_pc, wb_inst  out  WIDTH each  passed-through PC and instruction.
- wb_misalign  out  1  access was misaligned; no memory access was performed.

## Operation
The block is a three-state machine: IDLE, MEM, RESP.

- ex_ready = (state==IDLE) | (state==RESP & wb_ready).
- An instruction is accepted when ex_valid & ex_ready. On acceptance, every ex_* field is captured into registers.
- Misalignment rule:
  - half with addr[0]=1 is misaligned;
  - word with addr[1:0]≠0 is misaligned;
  - byte accesses are never misaligned.
- Transitions on acceptance:
  - a memory operation that is aligned goes to MEM;
  - anything else goes to RESP.
- Misaligned memory operation:
  - wb_misalign=1 and wb_rf_we=0;
  - mem_req is never asserted.
- MEM state:
  - mem_req=1, and mem_addr, mem_wr, mem_wdata and mem_wstrb are held stable.
  - On mem_ack, move to RESP. A load's data is extracted and registered in that cycle.
- RESP state:
  - wb_valid=1.
  - On wb_ready: move to IDLE if there is no new acceptance; if a new instruction is accepted in the same cycle, go straight to that instruction's next state.
- Store strobes: byte 4'b0001<<a[1:0]; half 4'b0011<<a[1:0]; word 4'b1111.
- Store data: byte {4{d[7:0]}}; half {2{d[15:0]}}; word d.
- Load extraction:
  - byte lane = rdata[8*a[1:0]+:8];
  - half lane = rdata[16*a[1]+:16];
  - the lane is sign-extended, or zero-extended when ex_mem_unsigned=1.
- Stores: wb_rf_wdata = captured alu_result. Stores also carry wb_rf_we through as captured; the decoder clears it.
- Non-memory instructions: wb_rf_wdata = alu_result.
- mem_ack outside MEM is ignored.
- wb_ready outside RESP is ignored.

## Timing
- Reset (rst=0 at a posedge):
  - state=IDLE;
  - mem_req=0 and wb_valid=0;
  - every registered output cleared to 0: wb_* fields, mem_addr, mem_wdata, mem_wstrb, mem_wr;
  - ex_ready=1 in the first cycle after reset.
- Reset during MEM abandons the transaction. A late mem_ack is ignored.
- Non-memory instruction accepted at cycle N: wb_valid=1 at N+1.
- Memory instruction accepted at cycle N:
  - mem_req=1 from N+1;
  - mem_ack at cycle M≥N+1 gives wb_valid=1 at M+1;
  - with zero-wait memory, the minimum load/store latency is 2 cycles.
- Back-to-back non-memory instructions with wb_ready held at 1 sustain one result per cycle.
- While wb_ready=0 in RESP, all wb_* outputs hold stable and ex_ready=0.
- mem_req never drops without a mem_ack, except on reset.

## Test plan
- Reset, then ALU op: alu_result=0x1234, rf_waddr=5, wb_ready=1. Required: wb_valid at N+1, wb_rf_wdata=0x1234, wb_rf_waddr=5, mem_req never asserted.
- LB at addr 0x1003, mem_rdata=0x80FFFFFF, ack after 2 wait cycles. Required: mem_addr=0x1000, mem_wr=0, wb_rf_wdata=0xFFFFFF80. Repeat with unsigned=1: wb_rf_wdata=0x00000080.
- SH at addr 0x2002, store_data=0xAABBCCDD. Required: mem_wstrb=4'b1100, mem_wdata=0xCCDDCCDD, mem_wr=1, mem_req held until ack.
- LW at addr 0x3001. Required: no mem_req, wb_misalign=1, wb_rf_we=0, wb_valid at N+1.
- wb_ready=0 for 3 cycles during RESP with ex_valid=1. Required: ex_ready=0 and wb_* outputs stable. When wb_ready rises, the next instruction is accepted in that same cycle.
- Assert rst=0 during MEM, and raise mem_ack in the following cycle. Required: IDLE, mem_req=0, wb_valid=0, and the ack produces no write-back.
